// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq: operand side (in_*) and result side (out_*).
// The ovf flag is only present when ALU_OVF_EN is defined.
interface alu_seq_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic [2:0]       opcode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] w;
   logic             zero;
   logic             neg;
   logic             cout;
`ifdef ALU_OVF_EN
   logic             ovf;
`endif

   modport master (
      output in_valid, a, b, cin, opcode, out_ready,
`ifdef ALU_OVF_EN
      input  ovf,
`endif
      input  in_ready, out_valid, w, zero, neg, cout
   );

   modport slave (
      input  in_valid, a, b, cin, opcode, out_ready,
`ifdef ALU_OVF_EN
      output ovf,
`endif
      output in_ready, out_valid, w, zero, neg, cout
   );
endinterface

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle add/sub/logic, shift-add MUL, bit-serial SHL.
// Optional signed-overflow flag (ovf) is enabled by defining ALU_OVF_EN.
module alu_seq #(
   parameter int WIDTH = 16
) (
   input  logic      clk,
   input  logic      rst,
   alu_seq_if.slave  bus
);
   localparam int SHW = $clog2(WIDTH);
   localparam int CW  = SHW + 1;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOT = 3'b101;
   localparam logic [2:0] OP_MUL = 3'b110;
   localparam logic [2:0] OP_SHL = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2:0]         op_q, op_d;
   logic [2*WIDTH-1:0] work_q, work_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [WIDTH-1:0]   w_q, w_d;
   logic               zero_q, zero_d;
   logic               neg_q, neg_d;
   logic               cout_q, cout_d;
   logic [WIDTH:0]     add_s, sub_s;
   logic [WIDTH-1:0]   res_s;
   logic               cout_s;
   logic               load_s;
   logic [SHW-1:0]     amt_s;
`ifdef ALU_OVF_EN
   logic [WIDTH-1:0]   a_orig_q, a_orig_d;
   logic [WIDTH-1:0]   b_orig_q, b_orig_d;
   logic [WIDTH-1:0]   hi_sgn_s;
   logic               ovf_q, ovf_d, ovf_s;
`endif

   // Datapath: operand capture, per-cycle MUL/SHL step, and result/flag update.
   always_comb begin
      add_s    = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin};
      sub_s    = {1'b0, bus.a} - {1'b0, bus.b} - {{WIDTH{1'b0}}, bus.cin};
      amt_s    = bus.b[SHW-1:0];
      work_d   = work_q;
      acc_d    = acc_q;
      mplier_d = mplier_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      load_s   = 1'b0;
      res_s    = w_q;
      cout_s   = cout_q;
`ifdef ALU_OVF_EN
      a_orig_d = a_orig_q;
      b_orig_d = b_orig_q;
      hi_sgn_s = {WIDTH{1'b0}};
      ovf_s    = ovf_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               op_d     = bus.opcode;
               work_d   = {{WIDTH{1'b0}}, bus.a};
               mplier_d = bus.b;
               acc_d    = {(2*WIDTH){1'b0}};
               cnt_d    = {CW{1'b0}};
               load_s   = 1'b1;
               cout_s   = 1'b0;
`ifdef ALU_OVF_EN
               a_orig_d = bus.a;
               b_orig_d = bus.b;
               ovf_s    = 1'b0;
`endif
               case (bus.opcode)
                  OP_ADD: begin
                     res_s  = add_s[WIDTH-1:0];
                     cout_s = add_s[WIDTH];
`ifdef ALU_OVF_EN
                     ovf_s  = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (add_s[WIDTH-1] != bus.a[WIDTH-1]);
`endif
                  end
                  OP_SUB: begin
                     res_s  = sub_s[WIDTH-1:0];
                     cout_s = sub_s[WIDTH];
`ifdef ALU_OVF_EN
                     ovf_s  = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sub_s[WIDTH-1] != bus.a[WIDTH-1]);
`endif
                  end
                  OP_AND:  res_s = bus.a & bus.b;
                  OP_OR:   res_s = bus.a | bus.b;
                  OP_XOR:  res_s = bus.a ^ bus.b;
                  OP_NOT:  res_s = ~bus.a;
                  OP_MUL: begin
                     load_s = 1'b0;
                     cnt_d  = CW'(WIDTH);
                  end
                  OP_SHL: begin
                     if (amt_s == {SHW{1'b0}}) begin
                        res_s = bus.a;
                     end else begin
                        load_s = 1'b0;
                        cnt_d  = {1'b0, amt_s};
                     end
                  end
                  default: res_s = w_q;
               endcase
            end else begin
               load_s = 1'b0;
            end
         end
         S_EXEC: begin
            cnt_d  = cnt_q - CW'(1);
            load_s = (cnt_q == CW'(1));
            work_d = work_q << 1;
            if (op_q == OP_MUL) begin
               // Shift-add: multiplicand doubles while multiplier bits are consumed LSB first.
               acc_d    = acc_q + (mplier_q[0] ? work_q : {(2*WIDTH){1'b0}});
               mplier_d = mplier_q >> 1;
               res_s    = acc_d[WIDTH-1:0];
               cout_s   = |acc_d[2*WIDTH-1:WIDTH];
`ifdef ALU_OVF_EN
               hi_sgn_s = acc_d[2*WIDTH-1:WIDTH]
                        - (a_orig_q[WIDTH-1] ? b_orig_q : {WIDTH{1'b0}})
                        - (b_orig_q[WIDTH-1] ? a_orig_q : {WIDTH{1'b0}});
               ovf_s    = (hi_sgn_s != {WIDTH{acc_d[WIDTH-1]}});
`endif
            end else begin
               // The bit that has just crossed position WIDTH is the last one shifted out.
               res_s  = work_d[WIDTH-1:0];
               cout_s = work_d[WIDTH];
`ifdef ALU_OVF_EN
               ovf_s  = 1'b0;
`endif
            end
         end
         S_DONE:  load_s = 1'b0;
         default: load_s = 1'b0;
      endcase

      if (load_s) begin
         w_d    = res_s;
         zero_d = (res_s == {WIDTH{1'b0}});
         neg_d  = res_s[WIDTH-1];
         cout_d = cout_s;
      end else begin
         w_d    = w_q;
         zero_d = zero_q;
         neg_d  = neg_q;
         cout_d = cout_q;
      end
`ifdef ALU_OVF_EN
      ovf_d = load_s ? ovf_s : ovf_q;
`endif
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               state_d = load_s ? S_DONE : S_EXEC;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_EXEC: begin
            if (cnt_q == CW'(1)) begin
               state_d = S_DONE;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_DONE: begin
            if (bus.out_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode.
   always_comb begin
      bus.in_ready  = (state_q == S_IDLE);
      bus.out_valid = (state_q == S_DONE);
      bus.w         = w_q;
      bus.zero      = zero_q;
      bus.neg       = neg_q;
      bus.cout      = cout_q;
`ifdef ALU_OVF_EN
      bus.ovf       = ovf_q;
`endif
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= {CW{1'b0}};
         op_q     <= 3'b000;
         work_q   <= {(2*WIDTH){1'b0}};
         acc_q    <= {(2*WIDTH){1'b0}};
         mplier_q <= {WIDTH{1'b0}};
         w_q      <= {WIDTH{1'b0}};
         zero_q   <= 1'b0;
         neg_q    <= 1'b0;
         cout_q   <= 1'b0;
`ifdef ALU_OVF_EN
         a_orig_q <= {WIDTH{1'b0}};
         b_orig_q <= {WIDTH{1'b0}};
         ovf_q    <= 1'b0;
`endif
      end else begin
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         work_q   <= work_d;
         acc_q    <= acc_d;
         mplier_q <= mplier_d;
         w_q      <= w_d;
         zero_q   <= zero_d;
         neg_q    <= neg_d;
         cout_q   <= cout_d;
`ifdef ALU_OVF_EN
         a_orig_q <= a_orig_d;
         b_orig_q <= b_orig_d;
         ovf_q    <= ovf_d;
`endif
      end
   end
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=16): per-feature tasks with hand-computed expectations.
module tb_alu_seq;
   localparam int W = 16;

   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   alu_seq_if #(.WIDTH(W)) bus();

   alu_seq #(.WIDTH(W)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Presents one operation, waits for out_valid and reports the latency in cycles.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic [2:0] op, output int lat, output bit busy_ok);
      @(negedge clk);
      bus.a        = a;
      bus.b        = b;
      bus.cin      = cin;
      bus.opcode   = op;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      lat     = 1;
      busy_ok = 1'b1;
      while (!bus.out_valid && lat < 200) begin
         if (bus.in_ready) busy_ok = 1'b0;
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic release_out();
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #12;
      n_tests++;
      if ({bus.out_valid, bus.w, bus.zero, bus.neg, bus.cout} !== 20'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got v=%b w=%h z=%b n=%b c=%b, exp all 0",
                  bus.out_valid, bus.w, bus.zero, bus.neg, bus.cout);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_tests++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_in_ready: got %b exp 1", bus.in_ready);
      end
   endtask

   task automatic test_add_sub();
      logic [15:0] va [4] = '{16'hFFFF, 16'h0005, 16'h7FFF, 16'h0007};
      logic [15:0] vb [4] = '{16'h0001, 16'h0007, 16'h0000, 16'h0007};
      logic        vc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      logic [2:0]  vo [4] = '{3'b000, 3'b001, 3'b000, 3'b001};
      logic [15:0] ew [4] = '{16'h0000, 16'hFFFE, 16'h8000, 16'hFFFF};
      logic [2:0]  ef [4] = '{3'b101, 3'b011, 3'b010, 3'b011};  // {zero,neg,cout}
      int lat;
      bit busy_ok;
      for (int i = 0; i < 4; i++) begin
         run_op(va[i], vb[i], vc[i], vo[i], lat, busy_ok);
         n_tests++;
         if (lat !== 1 || bus.w !== ew[i] || {bus.zero, bus.neg, bus.cout} !== ef[i]) begin
            n_fail++;
            $display("FAIL addsub_%0d: got lat=%0d w=%h znc=%b exp lat=1 w=%h znc=%b",
                     i, lat, bus.w, {bus.zero, bus.neg, bus.cout}, ew[i], ef[i]);
         end
         release_out();
      end
`ifdef ALU_OVF_EN
      run_op(16'h7FFF, 16'h0001, 1'b0, 3'b000, lat, busy_ok);
      n_tests++;
      if (bus.ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL add_ovf: got %b exp 1", bus.ovf);
      end
      release_out();
`endif
   endtask

   task automatic test_logic();
      logic [2:0]  vo [4] = '{3'b010, 3'b011, 3'b100, 3'b101};
      logic [15:0] ew [4] = '{16'hF000, 16'hFFF0, 16'h0FF0, 16'h0F0F};
      logic [2:0]  ef [4] = '{3'b010, 3'b010, 3'b000, 3'b000};
      int lat;
      bit busy_ok;
      for (int i = 0; i < 4; i++) begin
         run_op(16'hF0F0, 16'hFF00, 1'b1, vo[i], lat, busy_ok);
         n_tests++;
         if (lat !== 1 || bus.w !== ew[i] || {bus.zero, bus.neg, bus.cout} !== ef[i]) begin
            n_fail++;
            $display("FAIL logic_%0d: got lat=%0d w=%h znc=%b exp lat=1 w=%h znc=%b",
                     i, lat, bus.w, {bus.zero, bus.neg, bus.cout}, ew[i], ef[i]);
         end
         release_out();
      end
   endtask

   task automatic test_mul();
      logic [15:0] va [3] = '{16'h0100, 16'h0003, 16'hFFFF};
      logic [15:0] vb [3] = '{16'h0100, 16'h0005, 16'hFFFF};
      logic [15:0] ew [3] = '{16'h0000, 16'h000F, 16'h0001};
      logic [2:0]  ef [3] = '{3'b101, 3'b000, 3'b001};
      int lat;
      bit busy_ok;
      for (int i = 0; i < 3; i++) begin
         run_op(va[i], vb[i], 1'b0, 3'b110, lat, busy_ok);
         n_tests++;
         if (lat !== 17 || !busy_ok || bus.w !== ew[i] || {bus.zero, bus.neg, bus.cout} !== ef[i]) begin
            n_fail++;
            $display("FAIL mul_%0d: got lat=%0d busy_ok=%b w=%h znc=%b exp lat=17 busy_ok=1 w=%h znc=%b",
                     i, lat, busy_ok, bus.w, {bus.zero, bus.neg, bus.cout}, ew[i], ef[i]);
         end
         release_out();
      end
   endtask

   task automatic test_shl();
      logic [15:0] va [4] = '{16'hFF1F, 16'h1234, 16'h0003, 16'h0001};
      logic [15:0] vb [4] = '{16'h0003, 16'h0000, 16'h000F, 16'h0013};
      logic [15:0] ew [4] = '{16'hF8F8, 16'h1234, 16'h8000, 16'h0008};
      logic [2:0]  ef [4] = '{3'b011, 3'b000, 3'b011, 3'b000};
      int          el [4] = '{4, 1, 16, 4};
      int lat;
      bit busy_ok;
      for (int i = 0; i < 4; i++) begin
         run_op(va[i], vb[i], 1'b0, 3'b111, lat, busy_ok);
         n_tests++;
         if (lat !== el[i] || !busy_ok || bus.w !== ew[i] || {bus.zero, bus.neg, bus.cout} !== ef[i]) begin
            n_fail++;
            $display("FAIL shl_%0d: got lat=%0d w=%h znc=%b exp lat=%0d w=%h znc=%b",
                     i, lat, bus.w, {bus.zero, bus.neg, bus.cout}, el[i], ew[i], ef[i]);
         end
         release_out();
      end
   endtask

   task automatic test_backpressure();
      int lat;
      bit busy_ok;
      run_op(16'h0001, 16'h0002, 1'b0, 3'b000, lat, busy_ok);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.a        = 16'hFFFF;
         bus.b        = 16'h0001;
         bus.opcode   = 3'b001;
         bus.in_valid = 1'b1;
         @(posedge clk);
         #1;
         n_tests++;
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.w !== 16'h0003 ||
             {bus.zero, bus.neg, bus.cout} !== 3'b000) begin
            n_fail++;
            $display("FAIL backpressure_hold_%0d: got v=%b rdy=%b w=%h znc=%b exp v=1 rdy=0 w=0003 znc=000",
                     i, bus.out_valid, bus.in_ready, bus.w, {bus.zero, bus.neg, bus.cout});
         end
      end
      bus.in_valid = 1'b0;
      release_out();
      n_tests++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.w !== 16'h0003) begin
         n_fail++;
         $display("FAIL backpressure_release: got v=%b rdy=%b w=%h exp v=0 rdy=1 w=0003",
                  bus.out_valid, bus.in_ready, bus.w);
      end
   endtask

   task automatic test_reset_mid_mul();
      int lat;
      bit busy_ok;
      @(negedge clk);
      bus.a        = 16'h0003;
      bus.b        = 16'h0005;
      bus.opcode   = 3'b110;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      n_tests++;
      if ({bus.out_valid, bus.w, bus.zero, bus.neg, bus.cout} !== 20'h0) begin
         n_fail++;
         $display("FAIL reset_mid_mul: got v=%b w=%h z=%b n=%b c=%b exp all 0",
                  bus.out_valid, bus.w, bus.zero, bus.neg, bus.cout);
      end
      @(negedge clk);
      rst = 1'b0;
      run_op(16'h0003, 16'h0004, 1'b0, 3'b000, lat, busy_ok);
      n_tests++;
      if (lat !== 1 || bus.w !== 16'h0007 || {bus.zero, bus.neg, bus.cout} !== 3'b000) begin
         n_fail++;
         $display("FAIL post_reset_add: got lat=%0d w=%h znc=%b exp lat=1 w=0007 znc=000",
                  lat, bus.w, {bus.zero, bus.neg, bus.cout});
      end
      release_out();
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.a         = 16'h0000;
      bus.b         = 16'h0000;
      bus.cin       = 1'b0;
      bus.opcode    = 3'b000;
      test_reset();
      test_add_sub();
      test_logic();
      test_mul();
      test_shl();
      test_backpressure();
      test_reset_mid_mul();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
